ft601_rx_ctrl: RTL and testbench
================================

Name: ft601_rx_ctrl

Overview:
- Receive-side controller for the FT601 245-synchronous FIFO interface on the Lycan board. It sits directly downstream of the USB chip's RX FIFO.
- Sequences usb_outen_l and usb_rden_l, captures usb_data and usb_be, and buffers the captured words in an internal first-word-fall-through FIFO.
- Presents the words to the Lycan packet logic over a valid/ready stream.
- Throttles reads so that no captured word is ever lost.

Parameters:
- WIDTH, 32, data bus width. Byte-enable width is WIDTH/8.
- FIFO_DEPTH, 8, internal buffer depth in words. Must be a power of two and at least 4.
- MIN_FREE, 4, minimum free slots required before a new read burst may start. Legal range is 2..FIFO_DEPTH.

Ports:
- clk, in, 1, 100 MHz FT601 clock. All logic is on its rising edge.
- rst_l, in, 1, asynchronous active-low reset.
- usb_rx_empty, in, 1, FT601 RXF. 0 = data available; 1 = empty.
- usb_data, in, WIDTH, FT601 data bus. Read-only here; tri-state direction is handled at top level using usb_outen_l.
- usb_be, in, WIDTH/8, FT601 byte enables.
- usb_outen_l, out, 1, FT601 OE_N, active low.
- usb_rden_l, out, 1, FT601 RD_N, active low.
- m_data, out, WIDTH, head-of-FIFO data word.
- m_be, out, WIDTH/8, head-of-FIFO byte enables.
- m_valid, out, 1, the FIFO holds at least one word.
- m_ready, in, 1, consumer accepts the head word when m_valid && m_ready at a clock edge.
- rx_words, out, 16, count of captured words. Wraps modulo 2^16.
- busy, out, 1, high when the FSM is not in IDLE.

Behaviour:
- Reset (rst_l=0, asynchronous):
  - FSM to IDLE; usb_outen_l=1, usb_rden_l=1.
  - FIFO emptied; m_valid=0, m_data=0, m_be=0.
  - rx_words=0, busy=0.
  - A reset mid-burst aborts immediately. Words already captured are discarded.
- usb_outen_l and usb_rden_l are decoded only from the registered state. No combinational path from usb_rx_empty to either output.
- free = FIFO_DEPTH - count, sampled before the edge. Pops in the same cycle are ignored for read throttling (conservative).
- FSM states:
  - IDLE: outen_l=1, rden_l=1.
    - Go to OE when usb_rx_empty=0 and free >= MIN_FREE.
  - OE: outen_l=0, rden_l=1, lasts exactly one cycle (bus turnaround, FT601 requires OE before RD). Always go to READ.
  - READ: outen_l=0, rden_l=0.
    - Capture at every edge where usb_rx_empty=0: push {usb_be, usb_data}.
    - Words with usb_be==0 are not pushed and not counted.
    - Go to TURN when usb_rx_empty=1, or when free <= 1 (the capture at that same edge still occurs).
  - TURN: outen_l=1, rden_l=1, lasts exactly one cycle. Always go to IDLE, so the earliest next OE is 2 cycles after leaving READ.
- The exit rule guarantees no push while full. An assertion in the bench checks push && full never occurs.
- Latency: usb_rx_empty falling in IDLE gives:
  - rden_l low 2 cycles later;
  - first capture at the 3rd edge;
  - m_valid high immediately after that edge (FWFT).
- FIFO:
  - Simultaneous push and pop allowed at any occupancy, including full (pop frees, push refills) and empty (no bypass: the word appears on m_data the cycle after the push).
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - m_data and m_be hold stable while m_valid && !m_ready.
- rx_words increments by 1 per pushed word and wraps from 0xFFFF to 0.
- busy = (state != IDLE).

Test Plan:
- Basic burst: source preloaded with 8 words, m_ready=1, reset released at edge 0, rx_empty=0.
  - OE one cycle, then rden_l low for 9 cycles (8 captures plus 1 cycle sampling empty), then TURN, then IDLE.
  - Output words match the source order; rx_words=8.
- Backpressure: 12 words, m_ready=0.
  - Exactly 8 captured; rden_l rises at the 8th capture; m_valid stays 1; no overflow.
  - Raise m_ready for 4 pops (free=4): new burst starts; remaining 4 words arrive in order; rx_words=12.
- Source stall: rx_empty forced high for 5 cycles mid-burst.
  - FSM goes to TURN then IDLE, and resumes via OE on the next rx_empty=0.
  - No gaps or duplicates; total count is correct.
- Zero byte-enable: source presents a word with be=4'h0 between valid words.
  - That word is dropped; its neighbours pass; rx_words excludes it.
- Reset mid-burst: rst_l asserted during READ after 3 captures.
  - outen_l=1, rden_l=1, m_valid=0 immediately (asynchronously); rx_words=0.
  - After release, normal operation with a fresh source.
- Counter wrap: preload rx_words near 0xFFFE via 3 captures after a forced count, or a long run.
  - Verify the 0xFFFF to 0x0000 wrap.

Source files
------------

// File: rtl/ft601_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ft601_rx_ctrl
//  Purpose  : Receive-side controller for the FT601 245-synchronous FIFO
//             interface. Sequences OE_N/RD_N, captures data words with their
//             byte enables into a first-word-fall-through buffer, and hands
//             them downstream on a valid/ready stream. A new read burst starts
//             only when the buffer has enough free slots, so a captured word
//             can never be dropped.
//  Ports    : clk, rst_l            - clock / async active-low reset
//             usb_rx_empty          - FT601 RXF (0 = data available)
//             usb_data, usb_be      - FT601 data bus and byte enables
//             usb_outen_l           - FT601 OE_N (active low)
//             usb_rden_l            - FT601 RD_N (active low)
//             m_data, m_be, m_valid - head-of-buffer word, stream side
//             m_ready               - consumer accept
//             rx_words              - captured-word counter (wraps at 2^16)
//             busy                  - controller is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module ft601_rx_ctrl #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_FREE   = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               usb_rx_empty,
  input  logic [WIDTH-1:0]   usb_data,
  input  logic [WIDTH/8-1:0] usb_be,
  output logic               usb_outen_l,
  output logic               usb_rden_l,
  output logic [WIDTH-1:0]   m_data,
  output logic [WIDTH/8-1:0] m_be,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [15:0]        rx_words,
  output logic               busy
);

  localparam int c_BEW = WIDTH / 8;
  localparam int c_AW  = $clog2(FIFO_DEPTH);
  localparam int c_EW  = WIDTH + c_BEW;

  localparam logic [c_AW:0] c_DEPTH    = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [c_AW:0] c_MIN_FREE = (c_AW+1)'(MIN_FREE);
  localparam logic [c_AW:0] c_PTR_ONE  = (c_AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OE   = 2'd1,
    ST_READ = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;
  logic [c_AW:0]   w_count;
  logic [c_AW:0]   w_free;
  logic [c_EW-1:0] r_mem [FIFO_DEPTH];
  logic [c_EW-1:0] w_head;
  logic [15:0]     r_rx_words;
  logic            w_push;
  logic            w_pop;

  assign w_count = r_wr_ptr - r_rd_ptr;
  // Free space ignores a same-cycle pop, which keeps throttling conservative.
  assign w_free  = c_DEPTH - w_count;
  assign m_valid = (r_wr_ptr != r_rd_ptr);
  assign w_pop   = m_valid && m_ready;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!usb_rx_empty && (w_free >= c_MIN_FREE)) begin
          w_state_nxt = ST_OE;
        end
      end
      // One-cycle bus turnaround: the FT601 must see OE_N before RD_N.
      ST_OE: begin
        w_state_nxt = ST_READ;
      end
      ST_READ: begin
        // Zero byte-enable words are consumed from the chip but not kept.
        w_push = !usb_rx_empty && (usb_be != '0);
        // Leaving at free<=1 still takes this edge's word, which at most
        // fills the last slot; the burst cannot overrun the buffer.
        if (usb_rx_empty || (w_free <= c_PTR_ONE)) begin
          w_state_nxt = ST_TURN;
        end
      end
      ST_TURN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus strobes come only from the state register, never from usb_rx_empty.
  assign usb_outen_l = !((r_state == ST_OE) || (r_state == ST_READ));
  assign usb_rden_l  = (r_state != ST_READ);
  assign busy        = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // FWFT buffer and word counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rx_words <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
        r_rx_words <= r_rx_words + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {usb_be, usb_data};
    end
  end

  assign w_head   = r_mem[r_rd_ptr[c_AW-1:0]];
  assign m_data   = m_valid ? w_head[WIDTH-1:0]    : '0;
  assign m_be     = m_valid ? w_head[c_EW-1:WIDTH] : '0;
  assign rx_words = r_rx_words;

endmodule
`default_nettype wire

// File: tb/tb_ft601_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ft601_rx_ctrl
//  Purpose  : Self-checking bench for ft601_rx_ctrl. An emulated FT601 source
//             queue feeds the DUT; a behavioural model of the controller
//             (burst phases, buffered word queue, word count) predicts every
//             output on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ft601_rx_ctrl;

  localparam int WIDTH    = 32;
  localparam int BEW      = 4;
  localparam int DEPTH    = 8;
  localparam int MIN_FREE = 4;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             usb_rx_empty = 1'b1;
  logic [WIDTH-1:0] usb_data = '0;
  logic [BEW-1:0]   usb_be = '0;
  logic             usb_outen_l;
  logic             usb_rden_l;
  logic [WIDTH-1:0] m_data;
  logic [BEW-1:0]   m_be;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [15:0]      rx_words;
  logic             busy;

  always #5 clk = ~clk;

  ft601_rx_ctrl #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .MIN_FREE(MIN_FREE)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .usb_rx_empty(usb_rx_empty),
    .usb_data    (usb_data),
    .usb_be      (usb_be),
    .usb_outen_l (usb_outen_l),
    .usb_rden_l  (usb_rden_l),
    .m_data      (m_data),
    .m_be        (m_be),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .rx_words    (rx_words),
    .busy        (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [35:0] src_q[$];   // words still inside the emulated FT601
  logic [35:0] mq[$];      // model of the buffered words, head first
  bit          m_opening, m_reading, m_cool;
  logic [15:0] m_cnt;

  // Inputs and RD_N as presented during the cycle before the next edge.
  bit          p_empty, p_ready, p_rd_low;
  logic [31:0] p_data;
  logic [3:0]  p_be;

  int ready_mode = 1;      // 0: never, 1: always, 2: random
  int stall_cnt  = 0;
  bit rand_stall = 1'b0;
  int rd_low_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_opening = 1'b0;
    m_reading = 1'b0;
    m_cool    = 1'b0;
    m_cnt     = 16'd0;
  endtask

  // Behaviour of one rising edge, from the values present before it.
  task automatic model_edge();
    int free;
    bit cap, pop;
    free = DEPTH - mq.size();
    cap  = m_reading && !p_empty && (p_be != 4'h0);
    pop  = (mq.size() != 0) && p_ready;
    if (cap) chk("no_push_when_full", 64'(mq.size() < DEPTH), 64'd1);
    if (m_reading) begin
      if (p_empty || free <= 1) begin
        m_reading = 1'b0;
        m_cool    = 1'b1;
      end
    end else if (m_opening) begin
      m_opening = 1'b0;
      m_reading = 1'b1;
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (!p_empty && free >= MIN_FREE) begin
      m_opening = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (cap) begin
      mq.push_back({p_be, p_data});
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic compare_all();
    logic [35:0] head;
    head = (mq.size() != 0) ? mq[0] : 36'h0;
    chk("outen_l",  64'(usb_outen_l), 64'(!(m_opening || m_reading)));
    chk("rden_l",   64'(usb_rden_l),  64'(!m_reading));
    chk("busy",     64'(busy),        64'(m_opening || m_reading || m_cool));
    chk("m_valid",  64'(m_valid),     64'(mq.size() != 0));
    chk("m_data",   64'(m_data),      64'(head[31:0]));
    chk("m_be",     64'(m_be),        64'(head[35:32]));
    chk("rx_words", 64'(rx_words),    64'(m_cnt));
  endtask

  task automatic drive_inputs();
    if (rand_stall && stall_cnt == 0 && $urandom_range(0, 9) == 0)
      stall_cnt = $urandom_range(1, 4);
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    usb_rx_empty = (stall_cnt > 0) || (src_q.size() == 0);
    if (stall_cnt > 0) stall_cnt--;
    if (src_q.size() != 0) begin
      usb_be   = src_q[0][35:32];
      usb_data = src_q[0][31:0];
    end else begin
      usb_be   = 4'($urandom);
      usb_data = $urandom;
    end
    p_empty  = usb_rx_empty;
    p_ready  = m_ready;
    p_data   = usb_data;
    p_be     = usb_be;
    p_rd_low = (usb_rden_l == 1'b0);
    if (p_rd_low) rd_low_cycles++;
  endtask

  // One clock cycle: the emulated chip and the model react to the edge just
  // passed, outputs are checked, then the next inputs are applied.
  task automatic step();
    @(negedge clk);
    if (rst_l) begin
      if (p_rd_low && !p_empty) void'(src_q.pop_front());
      model_edge();
    end
    compare_all();
    drive_inputs();
  endtask

  task automatic load(input int n, input int zero_idx, input bit rand_be);
    for (int i = 0; i < n; i++) begin
      logic [3:0] be;
      be = 4'($urandom_range(1, 15));
      if (rand_be && $urandom_range(0, 7) == 0) be = 4'h0;
      if (i == zero_idx) be = 4'h0;
      src_q.push_back({be, 32'($urandom)});
    end
  endtask

  task automatic run_quiet(input int bound, input string tag);
    int n;
    n = 0;
    while ((src_q.size() != 0 || mq.size() != 0 || stall_cnt != 0 ||
            m_opening || m_reading || m_cool) && n < bound) begin
      step();
      n++;
    end
    chk({"done_in_time_", tag}, 64'(n < bound), 64'd1);
  endtask

  task automatic async_reset();
    #3 rst_l = 1'b0;
    #1;
    chk("rst_outen_l",  64'(usb_outen_l), 64'd1);
    chk("rst_rden_l",   64'(usb_rden_l),  64'd1);
    chk("rst_m_valid",  64'(m_valid),     64'd0);
    chk("rst_m_data",   64'(m_data),      64'd0);
    chk("rst_rx_words", 64'(rx_words),    64'd0);
    chk("rst_busy",     64'(busy),        64'd0);
    model_clear();
    src_q.delete();
    stall_cnt = 0;
    repeat (2) step();
    rst_l = 1'b1;
  endtask

  initial begin
    int first_rd, first_valid, guard;
    model_clear();
    p_empty = 1'b1; p_ready = 1'b0; p_rd_low = 1'b0; p_data = '0; p_be = '0;

    // Reset state
    repeat (3) step();
    chk("init_rx_words", 64'(rx_words), 64'd0);
    chk("init_m_valid",  64'(m_valid),  64'd0);

    // Basic burst: 8 words preloaded, consumer always ready
    ready_mode = 1;
    load(8, -1, 1'b0);
    step();
    rst_l = 1'b1;
    rd_low_cycles = 0; first_rd = 0; first_valid = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (first_rd == 0 && usb_rden_l == 1'b0) first_rd = i;
      if (first_valid == 0 && m_valid) first_valid = i;
    end
    chk("basic_first_rden",  64'(first_rd),      64'd2);
    chk("basic_first_valid", 64'(first_valid),   64'd3);
    chk("basic_rden_cycles", 64'(rd_low_cycles), 64'd9);
    chk("basic_rx_words",    64'(rx_words),      64'd8);

    // Backpressure: 12 words, consumer stalled
    ready_mode = 0;
    load(12, -1, 1'b0);
    repeat (30) step();
    chk("bp_rx_words",  64'(rx_words),     64'd16);
    chk("bp_src_left",  64'(src_q.size()), 64'd4);
    chk("bp_m_valid",   64'(m_valid),      64'd1);
    chk("bp_idle",      64'(busy),         64'd0);
    ready_mode = 1;
    repeat (4) step();
    ready_mode = 0;
    repeat (30) step();
    chk("bp2_rx_words", 64'(rx_words),     64'd20);
    chk("bp2_src_left", 64'(src_q.size()), 64'd0);
    ready_mode = 1;
    run_quiet(60, "bp");

    // Source stall mid-burst
    load(10, -1, 1'b0);
    repeat (5) step();
    stall_cnt = 5;
    run_quiet(80, "stall");
    chk("stall_rx_words", 64'(rx_words), 64'd30);

    // Zero byte-enable word between valid words
    load(5, 2, 1'b0);
    run_quiet(40, "zero_be");
    chk("zbe_rx_words", 64'(rx_words), 64'd34);

    // Reset after 3 captures of a burst
    ready_mode = 0;
    load(10, -1, 1'b0);
    guard = 0;
    while (m_cnt != 16'd37 && guard < 20) begin
      step();
      guard++;
    end
    chk("rst_reached_3_captures", 64'(guard < 20), 64'd1);
    chk("rst_mid_read", 64'(usb_rden_l), 64'd0);
    async_reset();
    ready_mode = 2;
    load(6, -1, 1'b0);
    run_quiet(100, "post_rst");
    chk("post_rst_rx_words", 64'(rx_words), 64'd6);

    // Random traffic: random ready, stalls and zero byte enables
    rand_stall = 1'b1;
    load(200, -1, 1'b1);
    run_quiet(4000, "random");
    rand_stall = 1'b0;

    // Counter wrap through 0xFFFF
    async_reset();
    ready_mode = 1;
    load(65538, -1, 1'b0);
    run_quiet(70000, "wrap");
    chk("wrap_rx_words", 64'(rx_words), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
